// File: rtl/alu.sv
// 8-bit registered ALU: 16 opcodes, 9-bit result, carry and zero flags, one cycle of latency.
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] op1,
  input  logic [7:0] op2,
  input  logic [3:0] opcode,
  output logic [8:0] result,
  output logic       carry_flag,
`ifdef ALU_OVERFLOW_FLAG_EN
  output logic       overflow_flag,
`endif
  output logic       zero_flag
);

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpXor  = 4'h4,
    OpNand = 4'h5,
    OpNor  = 4'h6,
    OpXnor = 4'h7,
    OpNot  = 4'h8,
    OpShl  = 4'h9,
    OpShr  = 4'hA,
    OpRol  = 4'hB,
    OpRor  = 4'hC,
    OpInc  = 4'hD,
    OpDec  = 4'hE,
    OpCmp  = 4'hF
  } op_e;

  logic [8:0] result_d, result_q;
  logic       carry_d, carry_q;
  logic       zero_d, zero_q;
  logic       ovf_d, ovf_q;
  op_e        op;

  assign op = op_e'(opcode);

  always_comb begin
    result_d = 9'h000;
    carry_d  = 1'b0;
    unique case (op)
      OpAdd: begin
        result_d = {1'b0, op1} + {1'b0, op2};
        carry_d  = result_d[8];
      end
      OpSub: begin
        result_d = {1'b0, op1} - {1'b0, op2};
        carry_d  = result_d[8];
      end
      OpAnd:  result_d = {1'b0, op1 & op2};
      OpOr:   result_d = {1'b0, op1 | op2};
      OpXor:  result_d = {1'b0, op1 ^ op2};
      OpNand: result_d = {1'b0, ~(op1 & op2)};
      OpNor:  result_d = {1'b0, ~(op1 | op2)};
      OpXnor: result_d = {1'b0, ~(op1 ^ op2)};
      OpNot:  result_d = {1'b0, ~op1};
      OpShl: begin
        result_d = {op1, 1'b0};
        carry_d  = op1[7];
      end
      OpShr: begin
        result_d = {2'b00, op1[7:1]};
        carry_d  = op1[0];
      end
      OpRol: begin
        result_d = {1'b0, op1[6:0], op1[7]};
        carry_d  = op1[7];
      end
      OpRor: begin
        result_d = {1'b0, op1[0], op1[7:1]};
        carry_d  = op1[0];
      end
      OpInc: begin
        result_d = {1'b0, op1} + 9'd1;
        carry_d  = result_d[8];
      end
      OpDec: begin
        result_d = {1'b0, op1} - 9'd1;
        carry_d  = result_d[8];
      end
      OpCmp: begin
        result_d = {6'b0, (op1 > op2), (op1 == op2), (op1 < op2)};
        carry_d  = (op1 < op2);
      end
      default: begin
        result_d = 9'h000;
        carry_d  = 1'b0;
      end
    endcase
    // Bit 8 is deliberately excluded so that 0x80+0x80 still reports zero.
    zero_d = (result_d[7:0] == 8'h00);
  end

  always_comb begin
    ovf_d = 1'b0;
    unique case (op)
      OpAdd:   ovf_d = (op1[7] == op2[7]) && (result_d[7] != op1[7]);
      OpSub:   ovf_d = (op1[7] != op2[7]) && (result_d[7] != op1[7]);
      OpInc:   ovf_d = (op1 == 8'h7F);
      OpDec:   ovf_d = (op1 == 8'h80);
      default: ovf_d = 1'b0;
    endcase
  end

  // resetn is active-high despite its name.
  always_ff @(posedge clock) begin
    if (resetn) begin
      result_q <= 9'h000;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

`ifdef ALU_OVERFLOW_FLAG_EN
  assign overflow_flag = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: reset, opcode sweep, borrow, zero flag, compare, hold and mid-stream reset.
module tb_alu;

  logic       clock;
  logic       resetn;
  logic [7:0] op1;
  logic [7:0] op2;
  logic [3:0] opcode;
  logic [8:0] result;
  logic       carry_flag;
  logic       zero_flag;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic       overflow_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu dut (
    .clock      (clock),
    .resetn     (resetn),
    .op1        (op1),
    .op2        (op2),
    .opcode     (opcode),
    .result     (result),
    .carry_flag (carry_flag),
`ifdef ALU_OVERFLOW_FLAG_EN
    .overflow_flag (overflow_flag),
`endif
    .zero_flag  (zero_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive inputs, then sample 1 time unit after the edge that registers them.
  task automatic step(input logic rst, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b);
    resetn = rst;
    opcode = op;
    op1    = a;
    op2    = b;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] exp_r, input logic exp_c,
                       input logic exp_z);
    n_cmp++;
    assert (result === exp_r) else begin
      n_err++;
      $error("FAIL %s result observed=%h expected=%h", tag, result, exp_r);
    end
    n_cmp++;
    assert (carry_flag === exp_c) else begin
      n_err++;
      $error("FAIL %s carry observed=%b expected=%b", tag, carry_flag, exp_c);
    end
    n_cmp++;
    assert (zero_flag === exp_z) else begin
      n_err++;
      $error("FAIL %s zero observed=%b expected=%b", tag, zero_flag, exp_z);
    end
  endtask

  initial begin
    resetn = 1'b1;
    opcode = 4'h0;
    op1    = 8'h00;
    op2    = 8'h00;

    // Reset with non-trivial inputs present.
    step(1'b1, 4'h0, 8'hFF, 8'hFF);
    check("reset", 9'h000, 1'b0, 1'b0);

    step(1'b0, 4'h0, 8'hBA, 8'hAB);
    check("add", 9'h165, 1'b1, 1'b0);
`ifdef ALU_OVERFLOW_FLAG_EN
    n_cmp++;
    assert (overflow_flag === 1'b1) else begin
      n_err++;
      $error("FAIL add_ovf observed=%b expected=1", overflow_flag);
    end
`endif

    // Sweep with op1=0xBA, op2=0xAB.
    step(1'b0, 4'h1, 8'hBA, 8'hAB); check("sub",  9'h00F, 1'b0, 1'b0);
    step(1'b0, 4'h2, 8'hBA, 8'hAB); check("and",  9'h0AA, 1'b0, 1'b0);
    step(1'b0, 4'h3, 8'hBA, 8'hAB); check("or",   9'h0BB, 1'b0, 1'b0);
    step(1'b0, 4'h4, 8'hBA, 8'hAB); check("xor",  9'h011, 1'b0, 1'b0);
    step(1'b0, 4'h5, 8'hBA, 8'hAB); check("nand", 9'h055, 1'b0, 1'b0);
    step(1'b0, 4'h6, 8'hBA, 8'hAB); check("nor",  9'h044, 1'b0, 1'b0);
    step(1'b0, 4'h7, 8'hBA, 8'hAB); check("xnor", 9'h0EE, 1'b0, 1'b0);

    // Mid-stream reset clears outputs, then the sweep resumes.
    step(1'b1, 4'h8, 8'hBA, 8'hAB); check("midreset", 9'h000, 1'b0, 1'b0);

    step(1'b0, 4'h8, 8'hBA, 8'hAB); check("not",  9'h045, 1'b0, 1'b0);
    step(1'b0, 4'h9, 8'hBA, 8'hAB); check("shl",  9'h174, 1'b1, 1'b0);
    step(1'b0, 4'hA, 8'hBA, 8'hAB); check("shr",  9'h05D, 1'b0, 1'b0);
    step(1'b0, 4'hB, 8'hBA, 8'hAB); check("rol",  9'h075, 1'b1, 1'b0);
    step(1'b0, 4'hC, 8'hBA, 8'hAB); check("ror",  9'h05D, 1'b0, 1'b0);
    step(1'b0, 4'hD, 8'hBA, 8'hAB); check("inc",  9'h0BB, 1'b0, 1'b0);
    step(1'b0, 4'hE, 8'hBA, 8'hAB); check("dec",  9'h0B9, 1'b0, 1'b0);
    step(1'b0, 4'hF, 8'hBA, 8'hAB); check("cmp",  9'h004, 1'b0, 1'b0);

    // Hold: inputs change between edges, outputs must not.
    opcode = 4'h0;
    op1    = 8'h01;
    op2    = 8'h01;
    #3;
    check("hold", 9'h004, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check("after_hold", 9'h002, 1'b0, 1'b0);

    // Borrow cases.
    step(1'b0, 4'h1, 8'h10, 8'h20); check("sub_borrow", 9'h1F0, 1'b1, 1'b0);
    step(1'b0, 4'hE, 8'h00, 8'h77); check("dec_borrow", 9'h1FF, 1'b1, 1'b0);

    // Zero flag ignores bit 8.
    step(1'b0, 4'h4, 8'h5A, 8'h5A); check("xor_zero", 9'h000, 1'b0, 1'b1);
    step(1'b0, 4'h0, 8'h80, 8'h80); check("add_zero", 9'h100, 1'b1, 1'b1);

    // Compare.
    step(1'b0, 4'hF, 8'h55, 8'h55); check("cmp_eq", 9'h002, 1'b0, 1'b0);
    step(1'b0, 4'hF, 8'h01, 8'hFF); check("cmp_lt", 9'h001, 1'b1, 1'b0);

    // Ops that ignore op2.
    step(1'b0, 4'hD, 8'hFF, 8'h12); check("inc_wrap", 9'h100, 1'b1, 1'b1);
    step(1'b0, 4'h8, 8'hFF, 8'h34); check("not_zero", 9'h000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
